// File: rtl/reset_sequencer.sv
// Staged boot/reset sequencer: after a hold time, CHANNELS active-high resets
// are released one per STAGE_GAP cycles. Masked soft requests re-arm selected channels.
module reset_sequencer #(
  parameter int CHANNELS  = 2,
  parameter int CYCLES    = 20,
  parameter int STAGE_GAP = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                soft_req,
  input  logic [CHANNELS-1:0] soft_mask,
  output logic [CHANNELS-1:0] reset_o,
  output logic                boot_done,
  output logic [7:0]          soft_count
);

  localparam int CW = $clog2(CYCLES + 1);
  localparam int GW = $clog2(STAGE_GAP + 1);
  localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  // Declaration initialisers match the reset values so configuration alone
  // starts a full boot sequence.
  state_e              state_q      = ST_HOLD;
  logic [CW-1:0]       cnt_q        = '0;
  logic [GW-1:0]       gap_q        = '0;
  logic [SW-1:0]       stage_q      = '0;
  logic [CHANNELS-1:0] pending_q    = '1;
  logic                boot_done_q  = 1'b0;
  logic [7:0]          soft_count_q = 8'd0;

  state_e              state_d;
  logic [CW-1:0]       cnt_d;
  logic [GW-1:0]       gap_d;
  logic [SW-1:0]       stage_d;
  logic [CHANNELS-1:0] pending_d;
  logic                boot_done_d;
  logic [7:0]          soft_count_d;
  logic                soft_accept;

  // Next-state logic: soft acceptance takes priority over normal sequencing.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    stage_d      = stage_q;
    pending_d    = pending_q;
    boot_done_d  = boot_done_q;
    soft_count_d = soft_count_q;
    soft_accept  = soft_req && (soft_mask != {CHANNELS{1'b0}});

    if (soft_accept) begin
      state_d      = ST_HOLD;
      cnt_d        = '0;
      gap_d        = '0;
      stage_d      = '0;
      pending_d    = pending_q | soft_mask;
      boot_done_d  = 1'b0;
      soft_count_d = (soft_count_q != 8'd255) ? (soft_count_q + 8'd1) : soft_count_q;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == CW'(CYCLES - 1)) begin
            cnt_d        = '0;
            gap_d        = '0;
            stage_d      = '0;
            pending_d[0] = 1'b0;
            if (CHANNELS == 1) begin
              state_d     = ST_RUN;
              boot_done_d = 1'b1;
            end else begin
              state_d     = ST_RELEASE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_RELEASE: begin
          // Every stage costs STAGE_GAP cycles even if its channel is not pending.
          if (gap_q == GW'(STAGE_GAP - 1)) begin
            gap_d   = '0;
            stage_d = stage_q + SW'(1);
            for (int i = 0; i < CHANNELS; i++) begin
              pending_d[i] = (stage_d == SW'(i)) ? 1'b0 : pending_q[i];
            end
            if (stage_d == SW'(CHANNELS - 1)) begin
              state_d     = ST_RUN;
              boot_done_d = 1'b1;
            end else begin
              state_d     = ST_RELEASE;
            end
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
        ST_RUN: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_HOLD;
        end
      endcase
    end
  end

  // State registers with synchronous reset to the boot values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_HOLD;
      cnt_q        <= '0;
      gap_q        <= '0;
      stage_q      <= '0;
      pending_q    <= '1;
      boot_done_q  <= 1'b0;
      soft_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      stage_q      <= stage_d;
      pending_q    <= pending_d;
      boot_done_q  <= boot_done_d;
      soft_count_q <= soft_count_d;
    end
  end

  assign reset_o    = pending_q;
  assign boot_done  = boot_done_q;
  assign soft_count = soft_count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: timing model from release-time arithmetic,
// directed scenarios with literal expectations, then randomized traffic.
module tb_reset_sequencer;

  localparam int CH  = 2;
  localparam int CY  = 20;
  localparam int GAP = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          soft_req;
  logic [CH-1:0] soft_mask;
  logic [CH-1:0] reset_o;
  logic          boot_done;
  logic [7:0]    soft_count;

  logic          soft_req2  = 1'b0;
  logic [3:0]    soft_mask2 = 4'b0000;
  logic [3:0]    reset_o2;
  logic          boot_done2;
  logic [7:0]    soft_count2;

  int total = 0;
  int bad   = 0;

  reset_sequencer #(.CHANNELS(CH), .CYCLES(CY), .STAGE_GAP(GAP)) dut (
    .clk(clk), .reset(reset), .soft_req(soft_req), .soft_mask(soft_mask),
    .reset_o(reset_o), .boot_done(boot_done), .soft_count(soft_count)
  );

  reset_sequencer #(.CHANNELS(4), .CYCLES(3), .STAGE_GAP(1)) dut2 (
    .clk(clk), .reset(reset), .soft_req(soft_req2), .soft_mask(soft_mask2),
    .reset_o(reset_o2), .boot_done(boot_done2), .soft_count(soft_count2)
  );

  always #5 clk = ~clk;

  // Model: edge index of last restart, mask armed at it, and an accept count.
  int          cyc_m  = 0;
  int          e0_m   = 0;
  logic [CH-1:0] pend_m = '1;
  int          cnt_m  = 0;

  function automatic logic [CH-1:0] exp_ro(input int c);
    logic [CH-1:0] r;
    for (int k = 0; k < CH; k++)
      r[k] = pend_m[k] && ((c - e0_m) < (CY + k * GAP));
    return r;
  endfunction

  function automatic logic exp_bd(input int c);
    return (c - e0_m) >= (CY + (CH - 1) * GAP);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      e0_m   <= cyc_m + 1;
      pend_m <= '1;
      cnt_m  <= 0;
    end else if (soft_req && soft_mask != '0) begin
      e0_m   <= cyc_m + 1;
      pend_m <= exp_ro(cyc_m) | soft_mask;
      if (cnt_m < 255) cnt_m <= cnt_m + 1;
    end
    cyc_m <= cyc_m + 1;
  end

  always @(negedge clk) begin
    total++;
    if (reset_o !== exp_ro(cyc_m) || boot_done !== exp_bd(cyc_m) || soft_count !== 8'(cnt_m)) begin
      bad++;
      $display("FAIL model cyc=%0d: got ro=%b bd=%b sc=%0d expected ro=%b bd=%b sc=%0d",
               cyc_m, reset_o, boot_done, soft_count, exp_ro(cyc_m), exp_bd(cyc_m), cnt_m);
    end
  end

  task automatic lit(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic step(input logic r, input logic sr, input logic [CH-1:0] m);
    @(negedge clk);
    reset = r; soft_req = sr; soft_mask = m;
  endtask

  initial begin
    reset = 1'b1; soft_req = 1'b0; soft_mask = '0;
    #1;
    lit("poweron_ro", int'(reset_o), 3);
    lit("poweron_bd", int'(boot_done), 0);
    step(1'b1, 1'b0, 2'b00);
    step(1'b1, 1'b1, 2'b11);
    // Power-on boot after a one-cycle reset; also the 4-channel instance.
    for (int j = 0; j < 30; j++) begin
      step(1'b0, 1'b0, 2'b00);
      if (j == 19) lit("boot_ch0_hi", int'(reset_o), 3);
      if (j == 20) lit("boot_ch0_lo", int'(reset_o), 2);
      if (j == 23) lit("boot_bd_lo", int'(boot_done), 0);
      if (j == 24) begin
        lit("boot_all_lo", int'(reset_o), 0);
        lit("boot_bd_hi", int'(boot_done), 1);
        lit("boot_sc", int'(soft_count), 0);
      end
      if (j == 2) lit("c4_e2", int'(reset_o2), 15);
      if (j == 3) lit("c4_e3", int'(reset_o2), 14);
      if (j == 4) lit("c4_e4", int'(reset_o2), 12);
      if (j == 5) begin
        lit("c4_e5", int'(reset_o2), 8);
        lit("c4_bd5", int'(boot_done2), 0);
      end
      if (j == 6) begin
        lit("c4_e6", int'(reset_o2), 0);
        lit("c4_bd6", int'(boot_done2), 1);
      end
    end
    // Soft request in RUN re-arming only channel 1.
    step(1'b0, 1'b1, 2'b10);
    for (int j = 0; j < 30; j++) begin
      step(1'b0, 1'b0, 2'b00);
      if (j == 0) begin
        lit("soft_ro", int'(reset_o), 2);
        lit("soft_bd", int'(boot_done), 0);
        lit("soft_sc", int'(soft_count), 1);
      end
      if (j == 23) lit("soft_ch1_hi", int'(reset_o), 2);
      if (j == 23) lit("soft_bd_lo", int'(boot_done), 0);
      if (j == 24) lit("soft_ch1_lo", int'(reset_o), 0);
      if (j == 24) lit("soft_bd_hi", int'(boot_done), 1);
    end
    // Ignored requests: empty mask, and request under reset.
    step(1'b0, 1'b1, 2'b00);
    step(1'b0, 1'b0, 2'b00);
    lit("mask0_ro", int'(reset_o), 0);
    lit("mask0_sc", int'(soft_count), 1);
    // Request during RELEASE just after channel 0 falls.
    step(1'b1, 1'b0, 2'b00);
    for (int j = 0; j < 20; j++) step(1'b0, 1'b0, 2'b00);
    step(1'b0, 1'b1, 2'b01);
    for (int j = 0; j < 26; j++) begin
      step(1'b0, 1'b0, 2'b00);
      if (j == 0) lit("rel_rearm", int'(reset_o), 3);
      if (j == 19) lit("rel_ch0_hi", int'(reset_o[0]), 1);
      if (j == 20) lit("rel_ch0_lo", int'(reset_o), 2);
      if (j == 24) lit("rel_ch1_lo", int'(reset_o), 0);
    end
    step(1'b1, 1'b1, 2'b11);
    step(1'b0, 1'b0, 2'b00);
    lit("req_in_reset_sc", int'(soft_count), 0);
    // Saturation of the accept counter, then reset clears it.
    for (int j = 0; j < 300; j++) step(1'b0, 1'b1, 2'(1 + (j % 3)));
    step(1'b0, 1'b0, 2'b00);
    lit("sat_sc", int'(soft_count), 255);
    step(1'b1, 1'b0, 2'b00);
    step(1'b0, 1'b0, 2'b00);
    lit("sat_clr", int'(soft_count), 0);
    // Randomized traffic against the model.
    for (int j = 0; j < 3000; j++) begin
      step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0,
           2'($urandom_range(0, 3)));
    end
    step(1'b0, 1'b0, 2'b00);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
